// File: rtl/echo_if.sv
// Sample/command bus of the echo generator: command strobe, sample strobe,
// processed output and the live delay/gain trim values.
interface echo_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 13
);
    logic [7:0]            cmd_data;
    logic                  cmd_valid;
    logic [DATA_WIDTH-1:0] sample_in;
    logic                  sample_valid;
    logic [DATA_WIDTH-1:0] sample_out;
    logic                  out_valid;
    logic [ADDR_WIDTH-1:0] delay_cur;
    logic [15:0]           gain_cur;

    modport master (
        output cmd_data, cmd_valid, sample_in, sample_valid,
        input  sample_out, out_valid, delay_cur, gain_cur
    );

    modport slave (
        input  cmd_data, cmd_valid, sample_in, sample_valid,
        output sample_out, out_valid, delay_cur, gain_cur
    );
endinterface

// File: rtl/echo_generator.sv
// Feed-forward echo adder: y[n] = sat(x[n] + (x[n-D]*G) >>> 15), three-stage
// pipeline advanced by sample strobes, D/G trimmed by UART command bytes.
module echo_generator #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 13,
    parameter int DEF_DELAY  = 7996,
    parameter int DEF_GAIN   = 32767,
    parameter int GAIN_STEP  = 200
) (
    input logic   clk,
    input logic   rst,
    echo_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = DATA_WIDTH + 16;

    localparam logic [ADDR_WIDTH-1:0] D_MAX = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] D_MIN = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] D_DEF = ADDR_WIDTH'(DEF_DELAY);
    localparam logic [ADDR_WIDTH-1:0] A_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [15:0] G_MAX    = 16'd32767;
    localparam logic [15:0] G_DEF    = 16'(DEF_GAIN);
    localparam logic [15:0] G_STEP   = 16'(GAIN_STEP);
    localparam logic [15:0] G_HI_LIM = G_MAX - G_STEP;
    localparam logic [DATA_WIDTH-1:0] S_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] S_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] S_ZERO = {DATA_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] delay_q, delay_d;
    logic [15:0]           gain_q, gain_d;
    logic [ADDR_WIDTH-1:0] fill_q, fill_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_addr_s;

    logic                  v1_q, v2_q, v3_q;
    logic [DATA_WIDTH-1:0] x1_q, x2_q, xd_q;
    logic                  mute1_q;
    logic [14:0]           g1_q;
    logic [DATA_WIDTH-1:0] echo_s, echo2_q;
    logic [DATA_WIDTH-1:0] out_q, sat_s;

    logic signed [PW-1:0]  xd_ext_s, g_ext_s, prod_s;
    logic [DATA_WIDTH:0]   sum_s;
    logic                  unused_s;

    // Command decode: saturating delay/gain trims
    always_comb begin
        delay_d = delay_q;
        gain_d  = gain_q;
        if (bus.cmd_valid) begin
            case (bus.cmd_data)
                8'h1F: begin
                    delay_d = D_DEF;
                    gain_d  = G_DEF;
                end
                8'h11: begin
                    if (delay_q != D_MAX) delay_d = delay_q + D_MIN;
                    else                  delay_d = delay_q;
                end
                8'h12: begin
                    if (delay_q > D_MIN) delay_d = delay_q - D_MIN;
                    else                 delay_d = D_MIN;
                end
                8'h19: begin
                    if (gain_q >= G_HI_LIM) gain_d = G_MAX;
                    else                    gain_d = gain_q + G_STEP;
                end
                8'h1A: begin
                    if (gain_q <= G_STEP) gain_d = 16'd0;
                    else                  gain_d = gain_q - G_STEP;
                end
                default: begin
                    delay_d = delay_q;
                    gain_d  = gain_q;
                end
            endcase
        end else begin
            delay_d = delay_q;
            gain_d  = gain_q;
        end
    end

    // History fill count: any real delay change invalidates the stored history
    always_comb begin
        fill_d = fill_q;
        if (delay_d != delay_q) begin
            fill_d = A_ZERO;
        end else if (bus.sample_valid && (fill_q < delay_q)) begin
            fill_d = fill_q + D_MIN;
        end else begin
            fill_d = fill_q;
        end
    end

    assign rd_addr_s = wr_ptr_q - delay_q;

    // Delay-line RAM, unreset; D>=1 keeps read and write addresses distinct
    always_ff @(posedge clk) begin
        if (bus.sample_valid) begin
            mem_q[wr_ptr_q] <= bus.sample_in;
            xd_q            <= mem_q[rd_addr_s];
        end
    end

    // Echo term: delayed sample times unsigned Q1.15 gain
    always_comb begin
        xd_ext_s = {{16{xd_q[DATA_WIDTH-1]}}, xd_q};
        g_ext_s  = {{(PW-15){1'b0}}, g1_q};
        prod_s   = xd_ext_s * g_ext_s;
        if (mute1_q) echo_s = S_ZERO;
        else         echo_s = prod_s[DATA_WIDTH+14:15];
    end

    assign unused_s = ^{prod_s[14:0], prod_s[PW-1]};

    // Output sum with two's-complement clamp
    always_comb begin
        sum_s = {x2_q[DATA_WIDTH-1], x2_q} + {echo2_q[DATA_WIDTH-1], echo2_q};
        if (sum_s[DATA_WIDTH] != sum_s[DATA_WIDTH-1]) begin
            sat_s = sum_s[DATA_WIDTH] ? S_MIN : S_MAX;
        end else begin
            sat_s = sum_s[DATA_WIDTH-1:0];
        end
    end

    // Control state and three-stage sample pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            delay_q  <= D_DEF;
            gain_q   <= G_DEF;
            fill_q   <= A_ZERO;
            wr_ptr_q <= A_ZERO;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            x1_q     <= S_ZERO;
            x2_q     <= S_ZERO;
            mute1_q  <= 1'b1;
            g1_q     <= 15'd0;
            echo2_q  <= S_ZERO;
            out_q    <= S_ZERO;
        end else begin
            delay_q <= delay_d;
            gain_q  <= gain_d;
            fill_q  <= fill_d;
            v1_q    <= bus.sample_valid;
            v2_q    <= v1_q;
            v3_q    <= v2_q;
            if (bus.sample_valid) begin
                wr_ptr_q <= wr_ptr_q + D_MIN;
                x1_q     <= bus.sample_in;
                mute1_q  <= (fill_q < delay_q);
                g1_q     <= gain_q[14:0];
            end
            if (v1_q) begin
                x2_q    <= x1_q;
                echo2_q <= echo_s;
            end
            if (v2_q) begin
                out_q <= sat_s;
            end
        end
    end

    assign bus.sample_out = out_q;
    assign bus.out_valid  = v3_q;
    assign bus.delay_cur  = delay_q;
    assign bus.gain_cur   = gain_q;
endmodule

// File: tb/tb_echo_generator.sv
// Directed bench for echo_generator: reset, command bounds, impulse echo,
// fill guard, saturation, pointer wrap at full rate, collision and mid-flight reset.
module tb_echo_generator;
    localparam int DW    = 16;
    localparam int AW    = 13;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    echo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifc ();

    echo_generator #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEF_DELAY(7996),
        .DEF_GAIN(32767), .GAIN_STEP(200)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc.slave)
    );

    task automatic send_cmd(input logic [7:0] c, input int reps);
        for (int i = 0; i < reps; i++) begin
            @(negedge clk);
            ifc.cmd_data  = c;
            ifc.cmd_valid = 1'b1;
        end
        @(negedge clk);
        ifc.cmd_valid = 1'b0;
    endtask

    task automatic send_sample(input logic [DW-1:0] x, output logic [DW-1:0] y, output bit got);
        @(negedge clk);
        ifc.sample_in    = x;
        ifc.sample_valid = 1'b1;
        @(negedge clk);
        ifc.sample_valid = 1'b0;
        got = 1'b0;
        y   = '0;
        for (int i = 0; i < 8 && !got; i++) begin
            if (ifc.out_valid) begin
                got = 1'b1;
                y   = ifc.sample_out;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    function automatic int wrap_exp(input int n);
        int s;
        s = n;
        if (n >= DEPTH - 1) s = n + (((n - (DEPTH - 1)) * 32767) >>> 15);
        if (s > 32767) s = 32767;
        return s;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks += 4;
        if (ifc.sample_out !== 16'd0) begin n_fail++; $display("FAIL reset_out got %0d want 0", ifc.sample_out); end
        if (ifc.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", ifc.out_valid); end
        if (ifc.delay_cur !== 13'd7996) begin n_fail++; $display("FAIL reset_delay got %0d want 7996", ifc.delay_cur); end
        if (ifc.gain_cur !== 16'd32767) begin n_fail++; $display("FAIL reset_gain got %0d want 32767", ifc.gain_cur); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cmd_bounds();
        logic [DW-1:0] y;
        bit got;
        logic [DW-1:0] xs [4];
        xs = '{16'd1234, 16'hFDD5, 16'h7FFF, 16'h8000};
        send_cmd(8'h19, 200);
        n_checks++;
        if (ifc.gain_cur !== 16'd32767) begin n_fail++; $display("FAIL gain_up_sat got %0d want 32767", ifc.gain_cur); end
        send_cmd(8'h1A, 200);
        n_checks++;
        if (ifc.gain_cur !== 16'd0) begin n_fail++; $display("FAIL gain_dn_sat got %0d want 0", ifc.gain_cur); end
        send_cmd(8'h55, 1);
        n_checks++;
        if (ifc.delay_cur !== 13'd7996 || ifc.gain_cur !== 16'd0) begin
            n_fail++; $display("FAIL ignored_cmd got D=%0d G=%0d want D=7996 G=0", ifc.delay_cur, ifc.gain_cur);
        end
        send_cmd(8'h12, 7995);
        n_checks++;
        if (ifc.delay_cur !== 13'd1) begin n_fail++; $display("FAIL delay_to_1 got %0d want 1", ifc.delay_cur); end
        send_cmd(8'h12, 1);
        n_checks++;
        if (ifc.delay_cur !== 13'd1) begin n_fail++; $display("FAIL delay_min_sat got %0d want 1", ifc.delay_cur); end
        for (int i = 0; i < 4; i++) begin
            send_sample(xs[i], y, got);
            n_checks++;
            if (!got || y !== xs[i]) begin n_fail++; $display("FAIL zero_gain[%0d] got %0d (valid %b) want %0d", i, $signed(y), got, $signed(xs[i])); end
        end
    endtask

    task automatic test_impulse();
        logic [DW-1:0] y;
        bit got;
        logic [DW-1:0] ex [10];
        ex = '{16'd1000, 16'd0, 16'd0, 16'd0, 16'd500, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        send_cmd(8'h11, 3);
        send_cmd(8'h19, 82);
        n_checks++;
        if (ifc.delay_cur !== 13'd4 || ifc.gain_cur !== 16'd16400) begin
            n_fail++; $display("FAIL impulse_setup got D=%0d G=%0d want D=4 G=16400", ifc.delay_cur, ifc.gain_cur);
        end
        for (int i = 0; i < 10; i++) begin
            send_sample((i == 0) ? 16'd1000 : 16'd0, y, got);
            n_checks++;
            if (!got || y !== ex[i]) begin n_fail++; $display("FAIL impulse[%0d] got %0d (valid %b) want %0d", i, $signed(y), got, ex[i]); end
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (ifc.sample_out !== 16'd0 || ifc.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL hold_idle got %0d/%b want 0/0", ifc.sample_out, ifc.out_valid);
        end
    endtask

    task automatic test_fill_guard();
        logic [DW-1:0] y;
        bit got;
        logic [DW-1:0] e;
        send_cmd(8'h11, 1);
        for (int i = 0; i < 8; i++) begin
            e = (i < 5) ? 16'd100 : 16'd150;
            send_sample(16'd100, y, got);
            n_checks++;
            if (!got || y !== e) begin n_fail++; $display("FAIL fill_guard[%0d] got %0d (valid %b) want %0d", i, $signed(y), got, e); end
        end
    endtask

    task automatic test_saturation();
        logic [DW-1:0] y;
        bit got;
        logic [DW-1:0] e;
        send_cmd(8'h12, 4);
        send_cmd(8'h19, 100);
        for (int i = 0; i < 4; i++) begin
            e = (i == 0) ? 16'd30000 : 16'd32767;
            send_sample(16'd30000, y, got);
            n_checks++;
            if (!got || y !== e) begin n_fail++; $display("FAIL sat_pos[%0d] got %0d (valid %b) want %0d", i, $signed(y), got, e); end
        end
        send_cmd(8'h11, 1);
        send_cmd(8'h12, 1);
        for (int i = 0; i < 4; i++) begin
            e = (i == 0) ? 16'h8AD0 : 16'h8000;
            send_sample(16'h8AD0, y, got);
            n_checks++;
            if (!got || y !== e) begin n_fail++; $display("FAIL sat_neg[%0d] got %0d (valid %b) want %0d", i, $signed(y), got, $signed(e)); end
        end
    endtask

    task automatic test_back_to_back_wrap();
        logic [DW-1:0] e;
        send_cmd(8'h11, DEPTH - 2);
        n_checks++;
        if (ifc.delay_cur !== 13'd8191) begin n_fail++; $display("FAIL delay_max got %0d want 8191", ifc.delay_cur); end
        send_cmd(8'h11, 1);
        n_checks++;
        if (ifc.delay_cur !== 13'd8191) begin n_fail++; $display("FAIL delay_max_sat got %0d want 8191", ifc.delay_cur); end
        for (int n = 0; n < 3 * DEPTH + 3; n++) begin
            @(negedge clk);
            n_checks++;
            if (n < 3) begin
                if (ifc.out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_early[%0d] got valid %b want 0", n, ifc.out_valid); end
            end else begin
                e = 16'(wrap_exp(n - 3));
                if (ifc.out_valid !== 1'b1 || ifc.sample_out !== e) begin
                    n_fail++; $display("FAIL wrap[%0d] got %0d (valid %b) want %0d", n - 3, ifc.sample_out, ifc.out_valid, e);
                end
            end
            if (n < 3 * DEPTH) begin
                ifc.sample_in    = 16'(n);
                ifc.sample_valid = 1'b1;
            end else begin
                ifc.sample_valid = 1'b0;
            end
        end
    endtask

    task automatic test_collision();
        logic [DW-1:0] y;
        bit got;
        logic [DW-1:0] ex [3];
        ex = '{16'd10, 16'd20, 16'd39};
        send_cmd(8'h1F, 1);
        n_checks++;
        if (ifc.delay_cur !== 13'd7996 || ifc.gain_cur !== 16'd32767) begin
            n_fail++; $display("FAIL cmd_default got D=%0d G=%0d want D=7996 G=32767", ifc.delay_cur, ifc.gain_cur);
        end
        send_cmd(8'h12, 7994);
        for (int i = 0; i < 3; i++) begin
            send_sample(16'(10 * (i + 1)), y, got);
            n_checks++;
            if (!got || y !== ex[i]) begin n_fail++; $display("FAIL coll_pre[%0d] got %0d (valid %b) want %0d", i, y, got, ex[i]); end
        end
        @(negedge clk);
        ifc.sample_in    = 16'd40;
        ifc.sample_valid = 1'b1;
        ifc.cmd_data     = 8'h11;
        ifc.cmd_valid    = 1'b1;
        @(negedge clk);
        ifc.sample_valid = 1'b0;
        ifc.cmd_valid    = 1'b0;
        got = 1'b0;
        y   = '0;
        for (int i = 0; i < 8 && !got; i++) begin
            if (ifc.out_valid) begin got = 1'b1; y = ifc.sample_out; end
            else @(negedge clk);
        end
        n_checks += 2;
        if (!got || y !== 16'd59) begin n_fail++; $display("FAIL coll_old_delay got %0d (valid %b) want 59", y, got); end
        if (ifc.delay_cur !== 13'd3) begin n_fail++; $display("FAIL coll_new_delay got %0d want 3", ifc.delay_cur); end
        send_sample(16'd50, y, got);
        n_checks++;
        if (!got || y !== 16'd50) begin n_fail++; $display("FAIL coll_muted got %0d (valid %b) want 50", y, got); end
    endtask

    task automatic test_reset_midflight();
        bit seen;
        @(negedge clk);
        ifc.sample_in    = 16'd1000;
        ifc.sample_valid = 1'b1;
        @(negedge clk);
        ifc.sample_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (ifc.out_valid) seen = 1'b1;
            @(negedge clk);
        end
        n_checks += 4;
        if (seen) begin n_fail++; $display("FAIL midflight_valid got a strobe want none"); end
        if (ifc.sample_out !== 16'd0) begin n_fail++; $display("FAIL midflight_out got %0d want 0", ifc.sample_out); end
        if (ifc.delay_cur !== 13'd7996) begin n_fail++; $display("FAIL midflight_delay got %0d want 7996", ifc.delay_cur); end
        if (ifc.gain_cur !== 16'd32767) begin n_fail++; $display("FAIL midflight_gain got %0d want 32767", ifc.gain_cur); end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.cmd_data     = 8'h00;
        ifc.cmd_valid    = 1'b0;
        ifc.sample_in    = 16'd0;
        ifc.sample_valid = 1'b0;
        test_reset();
        test_cmd_bounds();
        test_impulse();
        test_fill_guard();
        test_saturation();
        test_back_to_back_wrap();
        test_collision();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
